// File: rtl/ofdm_tx_pkg.sv
// Shared definitions for the OFDM transmit chain: default symbol geometry,
// read-FSM state encoding and the frame-counter wrap helper.
package ofdm_tx_pkg;

    localparam int DAT_W   = 12;
    localparam int DAT_NUM = 1024;
    localparam int CP_LEN  = 32;
    localparam int SB_NUM  = 50;
    localparam int FRAME_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_BODY = 2'd2
    } rd_state_e;

    function automatic logic [FRAME_W-1:0] frame_inc(
        input logic [FRAME_W-1:0] cur,
        input logic [FRAME_W-1:0] last
    );
        logic [FRAME_W-1:0] nxt;
        if (cur >= last) begin
            nxt = {FRAME_W{1'b0}};
        end else begin
            nxt = cur + FRAME_W'(1'b1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tx_cp_ram.sv
// Simple dual-port sample store (one write port, one read port) with a
// registered read that returns zero when no read is requested.
module tx_cp_ram #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port: idle reads park the output at zero so the top needs no mask
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end else begin
            rd_data <= {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/tx_cp_insert.sv
// Cyclic-prefix insertion: buffers IFFT symbols into two ping-pong banks and
// replays each as the last pCP_Len samples followed by the full body.
module tx_cp_insert
    import ofdm_tx_pkg::*;
#(
    parameter int pDAT_W   = DAT_W,
    parameter int pDAT_Num = DAT_NUM,
    parameter int pCP_Len  = CP_LEN,
    parameter int pSB_Num  = SB_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              isop,
    input  logic              ival,
    input  logic [pDAT_W-1:0] in_real_data,
    input  logic [pDAT_W-1:0] in_imag_data,
    output logic              iready,
    output logic              oval,
    output logic              osop,
    output logic              oeop,
    output logic              osof,
    output logic [pDAT_W-1:0] out_real_data,
    output logic [pDAT_W-1:0] out_imag_data,
    output logic [6:0]        count_frame,
    output logic              err_sop
);

    localparam int ADDR_W = $clog2(pDAT_Num);
    localparam int RAM_AW = ADDR_W + 1;
    localparam int RAM_DW = 2 * pDAT_W;

    localparam logic [ADDR_W-1:0]  ADDR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0]  BODY_LAST  = ADDR_W'(pDAT_Num - 1);
    localparam logic [ADDR_W-1:0]  CP_BASE    = ADDR_W'(pDAT_Num - pCP_Len);
    localparam logic [ADDR_W-1:0]  CP_LAST    = ADDR_W'(pCP_Len - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(pSB_Num - 1);

    // write side
    logic              wr_bank_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic              wr_active_r;
    logic [1:0]        full_r;
    logic              err_sop_r;

    logic              iready_s;
    logic              xfer_s;
    logic              wr_en_s;
    logic              wr_last_s;
    logic [RAM_AW-1:0] wr_ram_addr_s;
    logic [1:0]        full_set_s;
    logic [1:0]        full_clr_s;

    // read side
    rd_state_e         state_r;
    logic [ADDR_W-1:0] rd_cnt_r;
    logic              rd_bank_r;

    logic              rd_en_s;
    logic              ram_rd_en_s;
    logic [RAM_AW-1:0] rd_ram_addr_s;
    logic              rd_sop_s;
    logic              rd_eop_s;

    // output stage
    logic               oval_r;
    logic               osop_r;
    logic               oeop_r;
    logic               osof_r;
    logic [FRAME_W-1:0] count_frame_r;
    logic [FRAME_W-1:0] count_nxt_s;
    logic [RAM_DW-1:0]  ram_rd_data_s;

    assign iready_s = ~rst & ~full_r[wr_bank_r];
    assign xfer_s   = ival & iready_s;

    // Write addressing: isop always lands at address 0 of the current bank
    always_comb begin
        wr_en_s       = xfer_s & (isop | wr_active_r);
        wr_last_s     = 1'b0;
        wr_ram_addr_s = {wr_bank_r, ADDR_ZERO};
        if (isop) begin
            wr_ram_addr_s = {wr_bank_r, ADDR_ZERO};
        end else begin
            wr_ram_addr_s = {wr_bank_r, wr_addr_r};
            wr_last_s     = wr_en_s & (wr_addr_r == BODY_LAST);
        end
    end

    // Write pointer, bank selection and truncation detection
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_r   <= 1'b0;
            wr_addr_r   <= ADDR_ZERO;
            wr_active_r <= 1'b0;
            err_sop_r   <= 1'b0;
        end else begin
            err_sop_r <= xfer_s & isop & wr_active_r;
            if (wr_last_s) begin
                wr_bank_r   <= ~wr_bank_r;
                wr_addr_r   <= ADDR_ZERO;
                wr_active_r <= 1'b0;
            end else if (wr_en_s) begin
                wr_addr_r   <= isop ? ADDR_ONE : (wr_addr_r + ADDR_ONE);
                wr_active_r <= 1'b1;
            end else begin
                wr_addr_r   <= wr_addr_r;
                wr_active_r <= wr_active_r;
            end
        end
    end

    // Read address generation: CP replays the tail, BODY walks the whole bank
    always_comb begin
        rd_en_s       = 1'b0;
        rd_sop_s      = 1'b0;
        rd_eop_s      = 1'b0;
        rd_ram_addr_s = {rd_bank_r, ADDR_ZERO};
        case (state_r)
            ST_CP: begin
                rd_en_s       = 1'b1;
                rd_sop_s      = (rd_cnt_r == ADDR_ZERO);
                rd_ram_addr_s = {rd_bank_r, CP_BASE + rd_cnt_r};
            end
            ST_BODY: begin
                rd_en_s       = 1'b1;
                rd_eop_s      = (rd_cnt_r == BODY_LAST);
                rd_ram_addr_s = {rd_bank_r, rd_cnt_r};
            end
            default: begin
                rd_en_s = 1'b0;
            end
        endcase
    end

    assign ram_rd_en_s = rd_en_s & ~rst;

    // Set and clear always target different banks, so both apply together
    always_comb begin
        full_set_s = 2'b00;
        full_clr_s = 2'b00;
        if (wr_last_s) begin
            full_set_s[wr_bank_r] = 1'b1;
        end else begin
            full_set_s = 2'b00;
        end
        if (rd_eop_s) begin
            full_clr_s[rd_bank_r] = 1'b1;
        end else begin
            full_clr_s = 2'b00;
        end
    end

    // Bank full flags
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= 2'b00;
        end else begin
            full_r <= (full_r & ~full_clr_s) | full_set_s;
        end
    end

    // Read FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            rd_cnt_r  <= ADDR_ZERO;
            rd_bank_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rd_cnt_r <= ADDR_ZERO;
                    if (full_r[rd_bank_r]) begin
                        state_r <= ST_CP;
                    end
                end
                ST_CP: begin
                    if (rd_cnt_r == CP_LAST) begin
                        state_r  <= ST_BODY;
                        rd_cnt_r <= ADDR_ZERO;
                    end else begin
                        rd_cnt_r <= rd_cnt_r + ADDR_ONE;
                    end
                end
                ST_BODY: begin
                    if (rd_cnt_r == BODY_LAST) begin
                        rd_bank_r <= ~rd_bank_r;
                        rd_cnt_r  <= ADDR_ZERO;
                        state_r   <= full_r[~rd_bank_r] ? ST_CP : ST_IDLE;
                    end else begin
                        rd_cnt_r <= rd_cnt_r + ADDR_ONE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    rd_cnt_r <= ADDR_ZERO;
                end
            endcase
        end
    end

    assign count_nxt_s = oeop_r ? frame_inc(count_frame_r, FRAME_LAST) : count_frame_r;

    // Control outputs aligned with the one-cycle RAM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            oval_r        <= 1'b0;
            osop_r        <= 1'b0;
            oeop_r        <= 1'b0;
            osof_r        <= 1'b0;
            count_frame_r <= {FRAME_W{1'b0}};
        end else begin
            oval_r        <= rd_en_s;
            osop_r        <= rd_sop_s;
            oeop_r        <= rd_eop_s;
            osof_r        <= rd_sop_s & (count_nxt_s == {FRAME_W{1'b0}});
            count_frame_r <= count_nxt_s;
        end
    end

    tx_cp_ram #(
        .DATA_W (RAM_DW),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ram_addr_s),
        .wr_data ({in_real_data, in_imag_data}),
        .rd_en   (ram_rd_en_s),
        .rd_addr (rd_ram_addr_s),
        .rd_data (ram_rd_data_s)
    );

    assign iready        = iready_s;
    assign oval          = oval_r;
    assign osop          = osop_r;
    assign oeop          = oeop_r;
    assign osof          = osof_r;
    assign count_frame   = count_frame_r;
    assign err_sop       = err_sop_r;
    assign out_real_data = ram_rd_data_s[RAM_DW-1:pDAT_W];
    assign out_imag_data = ram_rd_data_s[pDAT_W-1:0];

endmodule

// File: tb/tb_tx_cp_insert.sv
// Randomized scoreboard bench for tx_cp_insert: a queue-based symbol model
// predicts every output sample, a negedge monitor compares them.
module tb_tx_cp_insert;

    localparam int W   = 12;
    localparam int N   = 1024;
    localparam int CPL = 32;
    localparam int SB  = 50;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         isop = 1'b0;
    logic         ival = 1'b0;
    logic [W-1:0] in_re = '0;
    logic [W-1:0] in_im = '0;
    logic         iready, oval, osop, oeop, osof, err_sop;
    logic [W-1:0] out_re, out_im;
    logic [6:0]   count_frame;

    always #5 clk = ~clk;

    tx_cp_insert #(
        .pDAT_W   (W),
        .pDAT_Num (N),
        .pCP_Len  (CPL),
        .pSB_Num  (SB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .isop          (isop),
        .ival          (ival),
        .in_real_data  (in_re),
        .in_imag_data  (in_im),
        .iready        (iready),
        .oval          (oval),
        .osop          (osop),
        .oeop          (oeop),
        .osof          (osof),
        .out_real_data (out_re),
        .out_imag_data (out_im),
        .count_frame   (count_frame),
        .err_sop       (err_sop)
    );

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         sop;
        logic         eop;
        logic         sof;
        logic [6:0]   frame;
    } exp_t;

    exp_t         expq[$];
    exp_t         e;
    logic [W-1:0] cur_re[$];
    logic [W-1:0] cur_im[$];
    bit collecting = 0;
    bit mon_en = 0;
    bit zero_chk = 0;
    bit in_sym = 0;
    bit prev_eop = 0;
    bit bb_mode = 0;
    bit saw_stall = 0;
    int sym_cnt = 0;
    int exp_err = 0;
    int got_err = 0;
    int out_syms = 0;
    int ncyc = 0;
    int lat_target = 0;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, ncyc);
        end
    endtask

    // Reference model: a completed symbol is its last CPL samples then all N
    task automatic push_symbol();
        exp_t x;
        int   idx;
        if (expq.size() == 0 && !oval) lat_target = ncyc + 3;
        for (int j = 0; j < N + CPL; j++) begin
            idx     = (j < CPL) ? (N - CPL + j) : (j - CPL);
            x.re    = cur_re[idx];
            x.im    = cur_im[idx];
            x.sop   = (j == 0);
            x.eop   = (j == N + CPL - 1);
            x.frame = 7'(sym_cnt % SB);
            x.sof   = (j == 0) && ((sym_cnt % SB) == 0);
            expq.push_back(x);
        end
        sym_cnt++;
        collecting = 0;
        cur_re.delete();
        cur_im.delete();
    endtask

    // Monitor first, then model update, in one process to avoid ordering races
    always @(negedge clk) begin
        ncyc++;
        if (mon_en) begin
            if (zero_chk) begin
                zero_chk = 0;
                chk("rst_outputs", {oval, osop, oeop, osof, err_sop, out_re, out_im}, 32'd0);
                chk("rst_count_frame", count_frame, 32'd0);
                chk("rst_iready", iready, rst ? 32'd0 : 32'd1);
            end
            if (in_sym || (bb_mode && prev_eop && expq.size() > 0))
                chk("oval_continuous", oval, 32'd1);
            if (oval) begin
                if (expq.size() == 0) begin
                    chk("spurious_oval", oval, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("data_re", out_re, e.re);
                    chk("data_im", out_im, e.im);
                    chk("osop", osop, e.sop);
                    chk("oeop", oeop, e.eop);
                    chk("osof", osof, e.sof);
                    chk("count_frame", count_frame, e.frame);
                    if (osop && lat_target != 0) begin
                        chk("sop_latency", ncyc, lat_target);
                        lat_target = 0;
                    end
                end
                if (osop) out_syms++;
                in_sym = !oeop;
            end else begin
                chk("idle_zero", {osop, oeop, osof, out_re, out_im}, 32'd0);
                in_sym = 0;
            end
            prev_eop = oval && oeop;
            if (err_sop) got_err++;
            if (bb_mode && !rst && !iready) saw_stall = 1;
        end
        if (rst) begin
            expq.delete();
            cur_re.delete();
            cur_im.delete();
            collecting = 0;
            sym_cnt = 0;
            in_sym = 0;
            prev_eop = 0;
            lat_target = 0;
            zero_chk = 1;
        end else if (ival && iready) begin
            if (isop) begin
                if (collecting) exp_err++;
                cur_re.delete();
                cur_im.delete();
                collecting = 1;
            end
            if (collecting) begin
                cur_re.push_back(in_re);
                cur_im.push_back(in_im);
                if (cur_re.size() == N) push_symbol();
            end
        end
    end

    task automatic drive(input logic [W-1:0] re, input logic [W-1:0] im, input logic sop);
        int   tries = 0;
        logic acc = 1'b0;
        in_re = re;
        in_im = im;
        isop  = sop;
        ival  = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = iready;
            @(posedge clk);
            #1;
            tries++;
            if (!acc && tries > 5000) begin
                chk("iready_timeout", tries, 32'd0);
                acc = 1'b1;
            end
        end
        isop = 1'b0;
    endtask

    task automatic send_samples(input int n, input bit ramp);
        logic [W-1:0] re, im;
        for (int k = 0; k < n; k++) begin
            re = ramp ? W'(k)  : W'($urandom);
            im = ramp ? W'(-k) : W'($urandom);
            drive(re, im, k == 0);
        end
    endtask

    task automatic drain(input string name);
        ival = 1'b0;
        for (int t = 0; t < 6000 && (expq.size() != 0 || in_sym); t++) @(posedge clk);
        #1;
        chk(name, expq.size(), 32'd0);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // pre-isop garbage must never reach the output
        for (int i = 0; i < 200; i++) begin
            in_re = W'($urandom);
            in_im = W'($urandom);
            ival  = 1'($urandom_range(0, 1));
            isop  = 1'b0;
            @(posedge clk);
            #1;
        end

        // 51 back-to-back symbols, the first one a ramp
        bb_mode = 1;
        send_samples(N, 1'b1);
        for (int s = 0; s < 50; s++) send_samples(N, 1'b0);
        drain("drain_b2b");
        bb_mode = 0;
        chk("stall_seen", saw_stall, 32'd1);
        chk("frame_after_51", count_frame, 32'(sym_cnt % SB));

        // truncated symbol followed by a complete one
        send_samples(500, 1'b0);
        send_samples(N, 1'b0);
        drain("drain_trunc");
        chk("err_sop_trunc", got_err, exp_err);

        // reset during the body of the third symbol of a burst
        base = out_syms;
        fork
            for (int s = 0; s < 5; s++) send_samples(N, 1'b0);
            begin
                for (int t = 0; t < 20000 && out_syms < base + 3; t++) @(posedge clk);
                if (out_syms < base + 3) chk("rst_wait", out_syms, base + 3);
                repeat (600) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        send_samples(N, 1'b0);
        drain("drain_after_rst");
        chk("err_sop_total", got_err, exp_err);
        chk("symbols_after_rst", (sym_cnt > 0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tx_cp_insert.md
TX_CP_INSERT -- requirements
Module: tx_cp_insert

Interface
REQ-001 Parameter pDAT_W, 12: sample component width (bits).
REQ-002 Parameter pDAT_Num, 1024: samples per OFDM symbol body (power of two).
REQ-003 Parameter pCP_Len, 32: cyclic-prefix length in samples (< pDAT_Num).
REQ-004 Parameter pSB_Num, 50: symbols per frame.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 isop  in  1  first body sample of a symbol from the IFFT.
REQ-008 ival  in  1  input sample valid.
REQ-009 in_real_data / in_imag_data  in  pDAT_W each  signed I/Q body samples.
REQ-010 iready  out  1  block accepts a sample this cycle; a transfer occurs on ival && iready.
REQ-011 oval  out  1  output sample valid; no backpressure on the output side.
REQ-012 osop / oeop  out  1 each  first CP sample / last body sample of a symbol.
REQ-013 osof  out  1  asserted with osop when count_frame == 0.
REQ-014 out_real_data / out_imag_data  out  pDAT_W each  signed I/Q samples with CP.
REQ-015 count_frame  out  7  index of the symbol currently output, 0..pSB_Num-1.
REQ-016 err_sop  out  1  one-cycle pulse on an isop that truncates a partial symbol.

Function
REQ-017 Storage: two ping-pong banks of pDAT_Num samples each; each bank carries a full flag.
REQ-018 Write: an accepted sample with isop goes to address 0; address then increments per transfer; accepted samples before the first isop are discarded.
REQ-019 Write completion: on accepting address pDAT_Num-1, the bank is set full and writing moves to the other bank.
REQ-020 Truncation: an isop at write address 0 < a < pDAT_Num restarts the same bank at 0 and pulses err_sop.
REQ-021 iready = 0 when the current write bank is full, otherwise 1.
REQ-022 Read FSM states: IDLE, CP, BODY.
REQ-023 IDLE -> CP when the read bank is full; CP reads addresses pDAT_Num-pCP_Len .. pDAT_Num-1 (992..1023), then goes to BODY.
REQ-024 BODY reads addresses 0..pDAT_Num-1; on the last read the bank full flag clears and the read bank toggles.
REQ-025 After the last BODY read: go to CP with no gap if the next bank is full, otherwise go to IDLE.
REQ-026 oval is high for exactly pCP_Len+pDAT_Num (1056) consecutive cycles per symbol.
REQ-027 Latency: osop rises exactly 3 cycles after the transfer that fills a bank, when the FSM is in IDLE.
REQ-028 Flag race: when a full flag is set and the other flag is cleared in the same cycle, both updates take effect; a bank under read is never written.
REQ-029 count_frame increments in the cycle after oeop and wraps pSB_Num-1 -> 0.
REQ-030 Data pass-through is bit-exact; there is no scaling or rounding.
REQ-031 When oval = 0, output data is 0.

Reset
REQ-032 While rst is high: all outputs are 0 (iready included), both banks are empty, the FSM is IDLE, count_frame is 0, and the write address is 0 awaiting isop.
REQ-033 iready = 1 from the first cycle after rst deasserts.
REQ-034 A reset mid-symbol discards all stored samples; no partial symbol is output after reset.

Structure
REQ-035 pDAT_W, pDAT_Num, pCP_Len, pSB_Num defaults and the FSM state enum live in shared package ofdm_tx_pkg.
REQ-036 Storage is a single sub-module tx_cp_ram: simple dual-port RAM, 2*pDAT_Num x 2*pDAT_W, 1-cycle read latency.

Verification
REQ-037 One symbol, input i=k, q=-k for k=0..1023 -> 1056 oval cycles; first output (992,-992) with osop and osof; sample 33 is (0,0); last is (1023,-1023) with oeop.
REQ-038 Back-to-back symbols with ival held high -> continuous oval across symbols, no gap; iready drops when both banks are full; no sample is lost or duplicated.
REQ-039 Input isop at write address 500, then a full symbol -> err_sop pulses once; the output contains only the full symbol.
REQ-040 51 symbols -> count_frame runs 0..49 then 0; osof occurs on symbols 0 and 50 only.
REQ-041 rst asserted for 1 cycle during BODY of symbol 2 -> outputs 0 the next cycle; the following symbol output is correct, with count_frame = 0.
REQ-042 ival before the first isop with 200 random samples -> no output; the first output symbol starts at the first isop sample.
